// File: rtl/onehot_decoder_pipe.sv
// Pipelined binary-to-one-hot decoder with a single-entry output register and a scan mode
// that walks every output line. Define ONEHOT_ZERO_MASK_EN to decode index 0 as all-zero.
module onehot_decoder_pipe #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned N_OUT  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out,
  output logic              out_err
);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_OUT - 1);
  // One extra bit so N_OUT == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   NOutExt = (ADDR_W + 1)'(N_OUT);

`ifdef ONEHOT_ZERO_MASK_EN
  localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(1);
  localparam bit                ZeroMask = 1'b1;
`else
  localparam logic [ADDR_W-1:0] FirstIdx = '0;
  localparam bit                ZeroMask = 1'b0;
`endif

  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [N_OUT-1:0]  r_out;
  logic              r_err;
  logic              r_out_valid;

  state_e            w_state_d;
  logic [ADDR_W-1:0] w_cnt_d;
  logic [N_OUT-1:0]  w_out_d;
  logic              w_err_d;
  logic              w_valid_d;
  logic              w_in_ready;
  logic              w_scan_busy;
  logic              w_free;
  logic              w_in_range;

  function automatic logic [N_OUT-1:0] f_decode(input logic [ADDR_W-1:0] idx);
    logic [N_OUT-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (idx == ADDR_W'(i)) v[i] = 1'b1;
    end
    if (ZeroMask && (idx == '0)) v = '0;
    return v;
  endfunction

  // Register can take a new value when empty or being drained this cycle.
  assign w_free     = !r_out_valid || out_ready;
  assign w_in_range = {1'b0, in_addr} < NOutExt;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_out_d     = r_out;
    w_err_d     = r_err;
    w_valid_d   = r_out_valid;
    w_in_ready  = 1'b0;
    w_scan_busy = 1'b0;

    if (r_out_valid && out_ready) w_valid_d = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (scan_start) begin
          // Scan wins over a same-cycle request; the request is not accepted.
          w_state_d = StScan;
          w_cnt_d   = FirstIdx;
        end else begin
          w_in_ready = w_free;
          if (in_valid && w_free) begin
            w_out_d   = w_in_range ? f_decode(in_addr) : '0;
            w_err_d   = !w_in_range;
            w_valid_d = 1'b1;
          end
        end
      end
      StScan: begin
        w_scan_busy = 1'b1;
        if (w_free) begin
          w_out_d   = f_decode(r_cnt);
          w_err_d   = 1'b0;
          w_valid_d = 1'b1;
          w_cnt_d   = r_cnt + ADDR_W'(1);
          if (r_cnt == LastIdx) w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_out       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_out       <= w_out_d;
      r_err       <= w_err_d;
      r_out_valid <= w_valid_d;
    end
  end

  assign in_ready  = w_in_ready;
  assign scan_busy = w_scan_busy;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_err   = r_err;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed bench for onehot_decoder_pipe: default instance plus an N_OUT=20 instance.
// Expectations follow ONEHOT_ZERO_MASK_EN when it is defined.
module tb_onehot_decoder_pipe;

`ifdef ONEHOT_ZERO_MASK_EN
  localparam int First = 1;
`else
  localparam int First = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, scan_start, scan_busy, out_valid, out_ready, out_err;
  logic [4:0]  in_addr;
  logic [31:0] out;

  logic        in2_valid, in2_ready, scan2_start, scan2_busy, out2_valid, out2_ready, out2_err;
  logic [4:0]  in2_addr;
  logic [19:0] out2;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  onehot_decoder_pipe #(.ADDR_W(5), .N_OUT(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .scan_start(scan_start), .scan_busy(scan_busy), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_err(out_err)
  );

  onehot_decoder_pipe #(.ADDR_W(5), .N_OUT(20)) dut20 (
    .clock(clock), .reset(reset), .in_valid(in2_valid), .in_ready(in2_ready),
    .in_addr(in2_addr), .scan_start(scan2_start), .scan_busy(scan2_busy),
    .out_valid(out2_valid), .out_ready(out2_ready), .out(out2), .out_err(out2_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_addr = 5'd3; out_ready = 1'b0; scan_start = 1'b0;
    in2_valid = 1'b1; in2_addr = 5'd3; out2_ready = 1'b0; scan2_start = 1'b0;
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0; in2_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    total++; if (out !== 32'h0) begin bad++; $display("FAIL rst_out got %h exp 0", out); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL rst_err got %b exp 0", out_err); end
    total++; if (scan_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b exp 0", scan_busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    total++; if (out2_valid !== 1'b0) begin bad++; $display("FAIL rst_valid20 got %b exp 0", out2_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_addr = 5'(i);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      exp = (First == 1 && i == 0) ? 32'h0 : (32'h1 << i);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, out_valid); end
      total++; if (out !== exp) begin bad++; $display("FAIL b2b_out[%0d] got %h exp %h", i, out, exp); end
      total++; if (out_err !== 1'b0) begin bad++; $display("FAIL b2b_err[%0d] got %b exp 0", i, out_err); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_out_of_range();
    out2_ready = 1'b1; in2_valid = 1'b1; in2_addr = 5'd25;
    tick();
    total++; if (out2 !== 20'h0) begin bad++; $display("FAIL oor_out got %h exp 0", out2); end
    total++; if (out2_err !== 1'b1) begin bad++; $display("FAIL oor_err got %b exp 1", out2_err); end
    total++; if (out2_valid !== 1'b1) begin bad++; $display("FAIL oor_valid got %b exp 1", out2_valid); end
    in2_addr = 5'd19;
    tick();
    total++; if (out2 !== 20'h80000) begin bad++; $display("FAIL top_out got %h exp 80000", out2); end
    total++; if (out2_err !== 1'b0) begin bad++; $display("FAIL top_err got %b exp 0", out2_err); end
    in2_valid = 1'b0;
    tick();
    total++; if (out2_valid !== 1'b0) begin bad++; $display("FAIL oor_drain got %b exp 0", out2_valid); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_addr = 5'd7; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (out !== 32'h80) begin bad++; $display("FAIL bp_out[%0d] got %h exp 80", k, out); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got %b exp 1", k, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got %b exp 0", k, in_ready); end
      if (k < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_handshake got %b exp 0", out_valid); end
  endtask

  task automatic test_scan();
    int nb;
    int busy_cnt;
    logic [31:0] exp;
    nb = 32 - First;
    in_valid = 1'b1; in_addr = 5'd5; scan_start = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL scan_prio_ready got %b exp 0", in_ready); end
    tick();
    scan_start = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (scan_busy !== 1'b1) begin bad++; $display("FAIL scan_enter got %b exp 1", scan_busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL scan_req_dropped got %b exp 0", out_valid); end
    busy_cnt = 1;
    for (int k = 0; k < nb; k++) begin
      tick();
      exp = 32'h1 << (First + k);
      if (scan_busy === 1'b1) busy_cnt++;
      total++; if (out !== exp) begin bad++; $display("FAIL scan_out[%0d] got %h exp %h", k, out, exp); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL scan_valid[%0d] got %b exp 1", k, out_valid); end
      total++; if (out_err !== 1'b0) begin bad++; $display("FAIL scan_err[%0d] got %b exp 0", k, out_err); end
      if (k < nb - 1) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL scan_ready[%0d] got %b exp 0", k, in_ready); end
      end else begin
        total++; if (scan_busy !== 1'b0) begin bad++; $display("FAIL scan_exit got %b exp 0", scan_busy); end
      end
    end
    total++; if (busy_cnt !== nb) begin bad++; $display("FAIL scan_busy_len got %0d exp %0d", busy_cnt, nb); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL scan_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] exp;
    exp = 32'h1 << (First + 10);
    out_ready = 1'b1; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    total++; if (out !== exp) begin bad++; $display("FAIL mid_beat10 got %h exp %h", out, exp); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    total++; if (out !== 32'h0) begin bad++; $display("FAIL mid_out got %h exp 0", out); end
    total++; if (scan_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got %b exp 0", scan_busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got %b exp 1", in_ready); end
    tick();
    total++; if (scan_busy !== 1'b0) begin bad++; $display("FAIL mid_resumed got %b exp 0", scan_busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid2 got %b exp 0", out_valid); end
  endtask

  task automatic test_zero_index();
    logic [31:0] exp;
    exp = (First == 1) ? 32'h0 : 32'h1;
    out_ready = 1'b1; in_valid = 1'b1; in_addr = 5'd0;
    tick();
    in_valid = 1'b0;
    total++; if (out !== exp) begin bad++; $display("FAIL zero_out got %h exp %h", out, exp); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL zero_err got %b exp 0", out_err); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_valid got %b exp 1", out_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_out_of_range();
    test_backpressure();
    test_scan();
    test_reset_mid_scan();
    test_zero_index();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_pipe.md
ONEHOT_DECODER_PIPE -- requirements
Module: onehot_decoder_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: width of the binary index input.
REQ-002 SHALL have parameter N_OUT, default 32: number of one-hot output lines; legal range 2..2**ADDR_W.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_addr carries a decode request.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port in_addr  input  ADDR_W  binary index to decode.
REQ-008 SHALL have port scan_start  input  1  pulse that starts a sequential walk of all outputs.
REQ-009 SHALL have port scan_busy  output  1  walk in progress.
REQ-010 SHALL have port out_valid  output  1  out/out_err hold a result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-012 SHALL have port out  output  N_OUT  registered one-hot (or all-zero) vector.
REQ-013 SHALL have port out_err  output  1  result came from an out-of-range index.

Function
REQ-014 SHALL hold one result in an output register; in_ready = !out_valid || out_ready while in IDLE, else 0.
REQ-015 SHALL accept a request when in_valid && in_ready; the result appears on out/out_valid the next cycle (latency 1).
REQ-016 SHALL, for in_addr < N_OUT, drive out with only bit in_addr set and out_err = 0.
REQ-017 SHALL, for in_addr >= N_OUT, drive out = 0 and out_err = 1.
REQ-018 SHALL keep out, out_err, out_valid stable while out_valid && !out_ready.
REQ-019 SHALL clear out_valid after a handshake (out_valid && out_ready) with no new load that cycle.
REQ-020 SHALL support full throughput: simultaneous output handshake and input accept reloads the register with no bubble.
REQ-021 SHALL implement FSM states IDLE and SCAN; reset state IDLE.
REQ-022 SHALL move IDLE -> SCAN on scan_start in IDLE, loading scan counter with the first index (0); scan_start outside IDLE is ignored.
REQ-023 SHALL give scan_start priority over a same-cycle in_valid; that request is not accepted (in_ready = 0 that cycle).
REQ-024 SHALL, in SCAN, load one-hot of the counter into the output register whenever the register is free or draining, then increment the counter.
REQ-025 SHALL return SCAN -> IDLE in the cycle index N_OUT-1 is loaded; scan_busy = 1 exactly while in SCAN.
REQ-026 SHALL never produce out_err = 1 during a scan.

Reset
REQ-027 SHALL, on reset high at a rising edge, set out = 0, out_err = 0, out_valid = 0, scan counter = 0, state IDLE, regardless of activity.
REQ-028 SHALL drive in_ready = 1 and scan_busy = 0 in the first cycle after reset deasserts; a scan interrupted by reset is not resumed.

Configuration
REQ-029 SHALL honour macro ONEHOT_ZERO_MASK_EN.
REQ-030 SHALL, with ONEHOT_ZERO_MASK_EN defined, decode in_addr = 0 to out = 0 with out_err = 0 and out_valid = 1, and start scans at index 1 (N_OUT-1 beats).
REQ-031 SHALL, without ONEHOT_ZERO_MASK_EN, decode index 0 to out bit 0 and scan all N_OUT indices.

Verification
REQ-032 SHALL cover: defaults, out_ready = 1, in_addr 0..31 back-to-back -> out = 1<<i one cycle later each, no gaps, out_err = 0.
REQ-033 SHALL cover: N_OUT = 20, in_addr = 25 -> out = 0, out_err = 1; in_addr = 19 -> out = 0x80000, out_err = 0.
REQ-034 SHALL cover: out_ready held 0 for 3 cycles after in_addr = 7 -> out stays 0x80, in_ready = 0, then single handshake on release.
REQ-035 SHALL cover: scan_start with out_ready = 1 -> 32 beats 0x1..0x80000000, scan_busy high 32 cycles, in_ready = 0 throughout.
REQ-036 SHALL cover: reset asserted mid-scan at beat 10 -> next cycle out_valid = 0, out = 0, scan_busy = 0, in_ready = 1.
REQ-037 SHALL cover: ONEHOT_ZERO_MASK_EN defined, in_addr = 0 -> out = 0, out_err = 0; scan -> 31 beats starting 0x2.
